// File: rtl/nrzi_unstuff_rx.sv
// NRZI decoder with bit-unstuffing, stuff-violation detection and LSB-first word assembly.
// All outputs are registered and update on the edge that samples shift_enable high.
module nrzi_unstuff_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STUFF_LEN  = 6,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_plus,
    input  logic              shift_enable,
    input  logic              eop,
    output logic              d_orig,
    output logic              bit_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              word_ready,
    output logic              stuff_err,
    output logic              partial_err
);

    localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);
    localparam int unsigned BitsW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_LEN);
    localparam logic [BitsW-1:0] BitsMax = BitsW'(DATA_W - 1);

    logic              prev_level_q, prev_level_d;
    logic              d_orig_q, d_orig_d;
    logic [OnesW-1:0]  ones_cnt_q, ones_cnt_d;
    logic [BitsW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              bit_valid_q, bit_valid_d;
    logic              word_ready_q, word_ready_d;
    logic              stuff_err_q, stuff_err_d;
    logic              partial_err_q, partial_err_d;
    logic              decoded;
    logic [DATA_W-1:0] sreg_shifted;

    always_comb begin
        prev_level_d  = prev_level_q;
        d_orig_d      = d_orig_q;
        ones_cnt_d    = ones_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sreg_d        = sreg_q;
        rx_data_d     = rx_data_q;
        stuff_err_d   = stuff_err_q;
        bit_valid_d   = 1'b0;
        word_ready_d  = 1'b0;
        partial_err_d = 1'b0;
        decoded       = (d_plus == prev_level_q);
        sreg_shifted  = {decoded, sreg_q[DATA_W-1:1]};

        if (shift_enable) begin
            if (eop) begin
                prev_level_d  = IDLE_LEVEL;
                d_orig_d      = 1'b1;
                ones_cnt_d    = '0;
                bit_cnt_d     = '0;
                sreg_d        = '0;
                stuff_err_d   = 1'b0;
                partial_err_d = (bit_cnt_q != '0);
            end else begin
                prev_level_d = d_plus;
                d_orig_d     = decoded;
                if (ones_cnt_q == OnesMax) begin
                    // Bit after a full run of ones: stuffed 0 or a violation; dropped either way.
                    ones_cnt_d = '0;
                    if (decoded) begin
                        stuff_err_d = 1'b1;
                    end
                end else begin
                    bit_valid_d = 1'b1;
                    ones_cnt_d  = decoded ? ones_cnt_q + 1'b1 : '0;
                    sreg_d      = sreg_shifted;
                    if (bit_cnt_q == BitsMax) begin
                        rx_data_d    = sreg_shifted;
                        word_ready_d = 1'b1;
                        bit_cnt_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_level_q  <= IDLE_LEVEL;
            d_orig_q      <= 1'b1;
            ones_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            sreg_q        <= '0;
            rx_data_q     <= '0;
            bit_valid_q   <= 1'b0;
            word_ready_q  <= 1'b0;
            stuff_err_q   <= 1'b0;
            partial_err_q <= 1'b0;
        end else begin
            prev_level_q  <= prev_level_d;
            d_orig_q      <= d_orig_d;
            ones_cnt_q    <= ones_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sreg_q        <= sreg_d;
            rx_data_q     <= rx_data_d;
            bit_valid_q   <= bit_valid_d;
            word_ready_q  <= word_ready_d;
            stuff_err_q   <= stuff_err_d;
            partial_err_q <= partial_err_d;
        end
    end

    assign d_orig      = d_orig_q;
    assign bit_valid   = bit_valid_q;
    assign rx_data     = rx_data_q;
    assign word_ready  = word_ready_q;
    assign stuff_err   = stuff_err_q;
    assign partial_err = partial_err_q;

endmodule
